// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one
// iteration per clock. Feeds the display selection/scan stage.
//
// Ports:
//   clk      - system clock, rising-edge
//   rst_n    - synchronous reset, active-HIGH (name kept for codebase consistency)
//   start    - conversion request, sampled only while idle
//   bin_in   - binary value, captured on the edge that accepts start
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse marking a completed conversion
//   bcd_out  - packed BCD result, most significant digit in the top nibble
//   overflow - last captured value exceeded 10^DIGITS - 1 (result saturated)
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    // Comparison width wide enough for both the input and the 32-bit limit.
    localparam int unsigned CMP_W = (BIN_W > 32) ? BIN_W : 32;

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [31:0] calc_max(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    localparam logic [31:0] MAX_VAL = calc_max(DIGITS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state, state_nxt;
    logic [SR_W-1:0]    sr, sr_nxt;
    logic [SR_W-1:0]    adj;
    logic [SR_W-1:0]    shifted;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf_pend, ovf_pend_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [BCD_W-1:0]   bcd_nxt;
    logic               overflow_nxt;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            cnt      <= cnt_nxt;
            ovf_pend <= ovf_pend_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            bcd_out  <= bcd_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        cnt_nxt      = cnt;
        ovf_pend_nxt = ovf_pend;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        bcd_nxt      = bcd_out;
        overflow_nxt = overflow;

        // Add 3 to every BCD nibble >= 5 (no inter-nibble carry), then shift.
        adj = sr;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (sr[BIN_W + 4*d +: 4] >= 4'd5) begin
                adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj[SR_W-2:0], 1'b0};

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    sr_nxt       = {{BCD_W{1'b0}}, bin_in};
                    cnt_nxt      = '0;
                    ovf_pend_nxt = (CMP_W'(bin_in) > CMP_W'(MAX_VAL));
                    busy_nxt     = 1'b1;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                sr_nxt  = shifted;
                cnt_nxt = cnt + CNT_W'(1);
                // Final iteration: publish the post-shift digits directly.
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    bcd_nxt      = ovf_pend ? {DIGITS{4'h9}} : shifted[SR_W-1 -: BCD_W];
                    overflow_nxt = ovf_pend;
                    done_nxt     = 1'b1;
                    busy_nxt     = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the display selection/scan stage.
- Turns the binary water-level measurement into packed BCD digits, which the display stage maps to 8-bit segment patterns.
- Uses one iteration per clock, so area stays small.

Parameters:
- BIN_W, 14: width of the binary input. Must be at least 1.
- DIGITS, 4: number of BCD output digits. Must satisfy 10^DIGITS - 1 < 2^32.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous reset, active-high: rst_n = 1 clears the block on the next rising edge of clk. The name is kept for consistency with the rest of the codebase.
- start  input  1  conversion request. Sampled only in IDLE.
- bin_in  input  BIN_W  binary value. Captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking a completed conversion.
- bcd_out  output  4*DIGITS  packed BCD result. The most significant digit is in the top nibble.
- overflow  output  1  the last captured value exceeded 10^DIGITS - 1.

Behaviour:

Reset:
- While rst_n = 1 at a rising edge, the block goes to IDLE.
- All of these clear to 0: busy, done, bcd_out, overflow, iteration counter, shift register.
- Reset has priority over every other event.

States: IDLE and SHIFT.

IDLE:
- busy = 0.
- If start = 1 at edge k:
  - Load the shift register with {4*DIGITS zeros, bin_in}; the register is 4*DIGITS + BIN_W bits.
  - Set cnt = 0 and ovf_pend = (bin_in > 10^DIGITS - 1).
  - Set busy = 1 and go to SHIFT.

SHIFT, one iteration per edge:
- Each BCD nibble that is >= 5 gets 3 added (4-bit result, no carry between nibbles).
- The whole register then shifts left by 1.
- cnt increments.
- start is ignored in this state: no restart and no queuing.

Completion:
- On the edge that performs iteration BIN_W (edge k + BIN_W), the block:
  - writes the upper 4*DIGITS bits to bcd_out, or all nibbles = 4'h9 if ovf_pend;
  - sets overflow = ovf_pend;
  - sets done = 1 and busy = 0;
  - returns to IDLE.
- Latency: the start edge to the done-high cycle is exactly BIN_W clocks. busy is high for exactly BIN_W cycles.

Output holding and timing:
- done clears on the following edge unless a new completion occurs on that edge.
- bcd_out and overflow hold their last completed values. They do not change during a conversion and do not change when start is accepted.
- start = 1 while done = 1 is accepted, because the state is IDLE. This allows back-to-back conversions every BIN_W + 1 cycles.
- A start held continuously high re-triggers a conversion each time the block is in IDLE.

Boundaries:
- bin_in = 0 gives bcd_out = 0 and overflow = 0.
- bin_in = 10^DIGITS - 1 gives all nines with overflow = 0.
- Any larger value saturates to all nines with overflow = 1.
- If BIN_W is too small to reach 10^DIGITS, overflow is never set.

Reset during SHIFT:
- The conversion is aborted and no done pulse is produced.
- bcd_out is cleared to 0.

Test Plan (defaults BIN_W = 14, DIGITS = 4):
- Assert reset, then release. Expect busy = 0, done = 0, bcd_out = 16'h0000, overflow = 0.
- Pulse start with bin_in = 1234 at edge k. Expect:
  - busy high for cycles k+1 .. k+14;
  - done high only in the cycle after edge k+14;
  - bcd_out = 16'h1234, overflow = 0;
  - bcd_out held at its previous value throughout the conversion.
- Run conversions of 0, 9, 10, 9999. Expect 16'h0000, 16'h0009, 16'h0010, 16'h9999, each with overflow = 0.
- Convert bin_in = 12000. Expect bcd_out = 16'h9999 and overflow = 1. A following conversion of 42 gives 16'h0042 with overflow = 0.
- Start 500. At cycle k+5, drive start = 1 with bin_in = 77. Expect that request ignored and result 16'h0500.
  - Then hold start high with bin_in = 77 through the done cycle. Expect a new conversion accepted on the done cycle, with the next done exactly 15 cycles after the previous done.
- Start 4321, then assert reset at cycle k+7. Expect no done pulse, bcd_out = 0, busy = 0.
  - After reset is released, converting 4321 yields 16'h4321.
